// File: rtl/weapon_fire_resolver.sv
// Weapon-fire consumer: resolves each Firing pulse against the enemy and sequences the fire animation.
// Optional hit flash for the HUD is built only when WEAPON_HIT_FLASH_EN is defined.
module weapon_fire_resolver #(
  parameter int HEALTH_W        = 4,
  parameter int MAX_HEALTH      = 10,
  parameter int DAMAGE          = 3,
  parameter int ANIM_FRAMES     = 4,
  parameter int FRAME_TICKS     = 6,
  parameter int HIT_FLASH_TICKS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     weapon_state,
  input  logic                           frame_tick,
  input  logic                           enemy_in_sight,
  input  logic                           respawn,
  output logic                           anim_active,
  output logic [$clog2(ANIM_FRAMES)-1:0] anim_frame,
  output logic [HEALTH_W-1:0]            enemy_health,
  output logic                           enemy_hit,
  output logic                           enemy_dead,
  output logic [7:0]                     kill_count,
  output logic                           hit_flash
);

  localparam int FW = $clog2(ANIM_FRAMES);
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [HEALTH_W-1:0] MAX_H      = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] DMG        = HEALTH_W'(DAMAGE);
  localparam logic [FW-1:0]       LAST_FRAME = FW'(ANIM_FRAMES - 1);
  localparam logic [TW-1:0]       LAST_TICK  = TW'(FRAME_TICKS - 1);

  if (ANIM_FRAMES < 2 || FRAME_TICKS < 1 || HIT_FLASH_TICKS < 1 ||
      MAX_HEALTH >= (1 << HEALTH_W)) begin : g_param_check
    $error("weapon_fire_resolver: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, RESOLVE, ANIM} state_t;

  state_t                state, state_nxt;
  logic                  sight_q, sight_nxt;
  logic [TW-1:0]         tick_cnt, tick_cnt_nxt;
  logic                  anim_active_nxt;
  logic [FW-1:0]         anim_frame_nxt;
  logic [HEALTH_W-1:0]   health_nxt;
  logic [HEALTH_W-1:0]   health_after_hit;
  logic                  hit_nxt;
  logic                  dead_nxt;
  logic [7:0]            kills_nxt;
  logic                  fire_evt;
  logic                  frame_done;

  // Only the exact Firing code counts; malformed one-hot values are dropped.
  assign fire_evt         = (weapon_state == 3'b010);
  assign frame_done       = frame_tick && (tick_cnt == LAST_TICK);
  assign health_after_hit = (enemy_health > DMG) ? (enemy_health - DMG) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire_evt) state_nxt = RESOLVE;
      RESOLVE: state_nxt = ANIM;
      ANIM:    if (frame_done && anim_frame == LAST_FRAME) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for every registered output; respawn overrides the resolve result.
  always_comb begin
    sight_nxt       = sight_q;
    tick_cnt_nxt    = tick_cnt;
    anim_active_nxt = anim_active;
    anim_frame_nxt  = anim_frame;
    health_nxt      = enemy_health;
    hit_nxt         = 1'b0;
    dead_nxt        = enemy_dead;
    kills_nxt       = kill_count;
    case (state)
      IDLE: begin
        if (fire_evt) begin
          sight_nxt       = enemy_in_sight;
          anim_active_nxt = 1'b1;
          anim_frame_nxt  = '0;
        end
      end
      RESOLVE: begin
        tick_cnt_nxt = '0;
        if (sight_q && !enemy_dead && !respawn) begin
          hit_nxt    = 1'b1;
          health_nxt = health_after_hit;
          if (health_after_hit == '0) begin
            dead_nxt = 1'b1;
            if (kill_count != 8'hFF) kills_nxt = kill_count + 8'd1;
          end
        end
      end
      ANIM: begin
        if (frame_tick) begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt_nxt = '0;
            if (anim_frame == LAST_FRAME) begin
              anim_active_nxt = 1'b0;
              anim_frame_nxt  = '0;
            end else begin
              anim_frame_nxt = anim_frame + FW'(1);
            end
          end else begin
            tick_cnt_nxt = tick_cnt + TW'(1);
          end
        end
      end
      default: ;
    endcase
    if (respawn) begin
      health_nxt = MAX_H;
      dead_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sight_q      <= 1'b0;
      tick_cnt     <= '0;
      anim_active  <= 1'b0;
      anim_frame   <= '0;
      enemy_health <= MAX_H;
      enemy_hit    <= 1'b0;
      enemy_dead   <= 1'b0;
      kill_count   <= 8'd0;
    end else begin
      sight_q      <= sight_nxt;
      tick_cnt     <= tick_cnt_nxt;
      anim_active  <= anim_active_nxt;
      anim_frame   <= anim_frame_nxt;
      enemy_health <= health_nxt;
      enemy_hit    <= hit_nxt;
      enemy_dead   <= dead_nxt;
      kill_count   <= kills_nxt;
    end
  end

`ifdef WEAPON_HIT_FLASH_EN
  localparam int FLW = (HIT_FLASH_TICKS > 1) ? $clog2(HIT_FLASH_TICKS) : 1;
  localparam logic [FLW-1:0] LAST_FLASH = FLW'(HIT_FLASH_TICKS - 1);

  logic [FLW-1:0] flash_cnt;

  // A new hit restarts the flash window even while it is already lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_flash <= 1'b0;
      flash_cnt <= '0;
    end else if (hit_nxt) begin
      hit_flash <= 1'b1;
      flash_cnt <= '0;
    end else if (hit_flash && frame_tick) begin
      if (flash_cnt == LAST_FLASH) begin
        hit_flash <= 1'b0;
        flash_cnt <= '0;
      end else begin
        flash_cnt <= flash_cnt + FLW'(1);
      end
    end
  end
`else
  assign hit_flash = 1'b0;
`endif

endmodule

// File: tb/tb_weapon_fire_resolver.sv
// Scoreboard bench for weapon_fire_resolver: directed shots push expected START/HIT/END events
// that a negedge monitor pops and compares, plus direct checks of reset and idle values.
module tb_weapon_fire_resolver;

  logic       clk;
  logic       rst;
  logic [2:0] weapon_state;
  logic       frame_tick;
  logic       enemy_in_sight;
  logic       respawn;
  logic       anim_active;
  logic [1:0] anim_frame;
  logic [3:0] enemy_health;
  logic       enemy_hit;
  logic       enemy_dead;
  logic [7:0] kill_count;
  logic       hit_flash;

  typedef enum int {EV_START, EV_HIT, EV_END} ev_t;
  typedef struct {
    ev_t kind;
    int  health;
    int  dead;
    int  kills;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_in_anim = 0;
  logic prev_active = 1'b0;

  weapon_fire_resolver dut (
    .clk            (clk),
    .rst            (rst),
    .weapon_state   (weapon_state),
    .frame_tick     (frame_tick),
    .enemy_in_sight (enemy_in_sight),
    .respawn        (respawn),
    .anim_active    (anim_active),
    .anim_frame     (anim_frame),
    .enemy_health   (enemy_health),
    .enemy_hit      (enemy_hit),
    .enemy_dead     (enemy_dead),
    .kill_count     (kill_count),
    .hit_flash      (hit_flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return the pulse inputs to their quiet values.
  task automatic applyStimulus(input logic [2:0] ws, input logic sight, input logic tick,
                               input logic resp);
    weapon_state   = ws;
    enemy_in_sight = sight;
    frame_tick     = tick;
    respawn        = resp;
    @(posedge clk);
    #1;
    weapon_state = 3'b001;
    frame_tick   = 1'b0;
    respawn      = 1'b0;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(3'b001, enemy_in_sight, 1'b1, 1'b0);
      applyStimulus(3'b001, enemy_in_sight, 1'b0, 1'b0);
    end
  endtask

  task automatic pushExp(input ev_t kind, input int h, input int d, input int k);
    exp_t e;
    e.kind   = kind;
    e.health = h;
    e.dead   = d;
    e.kills  = k;
    exp_q.push_back(e);
  endtask

  // Fire, spend the resolve cycle (optionally with respawn), then play n ticks of animation.
  task automatic fireShot(input logic sight, input bit exp_hit, input int h, input int d,
                          input int k, input bit resp, input int n_ticks);
    pushExp(EV_START, 0, 0, 0);
    if (exp_hit) pushExp(EV_HIT, h, d, k);
    if (resp) pushExp(EV_END, 10, 0, k);
    else      pushExp(EV_END, h, d, k);
    applyStimulus(3'b010, sight, 1'b0, 1'b0);
    applyStimulus(3'b001, sight, 1'b0, resp);
    runTicks(n_ticks);
  endtask

  task automatic checkIdle(input string tag, input int h, input int d, input int k);
    checkOutput({tag, " anim_active"}, anim_active, 0);
    checkOutput({tag, " anim_frame"}, anim_frame, 0);
    checkOutput({tag, " health"}, enemy_health, h);
    checkOutput({tag, " enemy_hit"}, enemy_hit, 0);
    checkOutput({tag, " enemy_dead"}, enemy_dead, d);
    checkOutput({tag, " kill_count"}, kill_count, k);
    checkOutput({tag, " hit_flash"}, hit_flash, 0);
  endtask

  task automatic handleEvent(input ev_t kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected event: got kind %0d expected none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event kind", kind, e.kind);
      if (kind == EV_START) begin
        checkOutput("start frame", anim_frame, 0);
      end else begin
        checkOutput("event health", enemy_health, e.health);
        checkOutput("event dead", enemy_dead, e.dead);
        checkOutput("event kills", kill_count, e.kills);
        if (kind == EV_END) checkOutput("anim ticks", tick_in_anim, 24);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_active  = 1'b0;
      tick_in_anim = 0;
    end else begin
      if (anim_active && !prev_active) begin
        tick_in_anim = 0;
        handleEvent(EV_START);
      end
      if (enemy_hit) handleEvent(EV_HIT);
      if (!anim_active && prev_active) handleEvent(EV_END);
      if (anim_active && frame_tick && tick_in_anim < 24) begin
        checkOutput("frame at tick", anim_frame, tick_in_anim / 6);
        tick_in_anim++;
      end
      prev_active = anim_active;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    weapon_state   = 3'b001;
    frame_tick     = 1'b0;
    enemy_in_sight = 1'b0;
    respawn        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset", 10, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) applyStimulus(3'b001, 1'b0, logic'(i % 2), 1'b0);
    checkIdle("idle", 10, 0, 0);

    // Five sighted shots: 7, 4, 1, kill at 0, then a shot at a dead enemy.
    fireShot(1'b1, 1'b1, 7, 0, 0, 1'b0, 24);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    fireShot(1'b1, 1'b1, 4, 0, 0, 1'b0, 24);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    fireShot(1'b1, 1'b1, 1, 0, 0, 1'b0, 24);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    fireShot(1'b1, 1'b1, 0, 1, 1, 1'b0, 24);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    fireShot(1'b1, 1'b0, 0, 1, 1, 1'b0, 24);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    checkIdle("after kill", 0, 1, 1);

    applyStimulus(3'b001, 1'b1, 1'b0, 1'b1);
    checkIdle("respawn", 10, 0, 1);

    // Fire during frame 1 is ignored; animation still ends after 24 ticks.
    fireShot(1'b1, 1'b1, 7, 0, 1, 1'b0, 7);
    checkOutput("frame before late fire", anim_frame, 1);
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0);
    runTicks(17);
    applyStimulus(3'b011, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    checkIdle("illegal state", 7, 0, 1);

    // Bring health to 1, then respawn on the killing resolve.
    fireShot(1'b1, 1'b1, 4, 0, 1, 1'b0, 24);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    fireShot(1'b1, 1'b1, 1, 0, 1, 1'b0, 24);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    fireShot(1'b1, 1'b0, 0, 0, 1, 1'b1, 0);
    checkOutput("respawn win health", enemy_health, 10);
    checkOutput("respawn win hit", enemy_hit, 0);
    checkOutput("respawn win kills", kill_count, 1);
    runTicks(24);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    checkIdle("respawn win", 10, 0, 1);

    // Reset in the middle of frame 2.
    fireShot(1'b1, 1'b1, 7, 0, 1, 1'b0, 13);
    checkOutput("frame before rst", anim_frame, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pending after rst", exp_q.size(), 1);
    exp_q.delete();
    checkIdle("mid-anim rst", 10, 0, 0);
    rst = 1'b0;
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);

`ifdef WEAPON_HIT_FLASH_EN
    fireShot(1'b1, 1'b1, 7, 0, 0, 1'b0, 0);
    checkOutput("flash on hit", hit_flash, 1);
    runTicks(7);
    checkOutput("flash after 7", hit_flash, 1);
    runTicks(1);
    checkOutput("flash after 8", hit_flash, 0);
    runTicks(16);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    fireShot(1'b1, 1'b1, 4, 0, 0, 1'b0, 0);
    checkOutput("flash on second hit", hit_flash, 1);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pending after flash rst", exp_q.size(), 1);
    exp_q.delete();
    checkOutput("flash after rst", hit_flash, 0);
    rst = 1'b0;
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
`else
    fireShot(1'b1, 1'b1, 7, 0, 0, 1'b0, 0);
    checkOutput("flash tied low", hit_flash, 0);
    runTicks(24);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    checkIdle("flash off", 7, 0, 0);
`endif

    repeat (2) applyStimulus(3'b001, 1'b0, 1'b0, 1'b0);
    checkOutput("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
